// File: rtl/regfile_scoreboard_if.sv
// Bus between the pipeline (decode/writeback) and the scoreboarded register file.
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
);
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                clr_req;
  logic                ready;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
    input  rd_data, rd_busy, ready
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
    output rd_data, rd_busy, ready
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with per-register busy scoreboard and a
// sequential clear sweep that zeroes x1..x(NREGS-1) after reset or on request.
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_scoreboard_if.slave   bus
);

  localparam logic [0:0]    ST_CLEAR  = 1'b0;
  localparam logic [0:0]    ST_RUN    = 1'b1;
  localparam logic [AW-1:0] IDX_FIRST = AW'(1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(NREGS - 1);
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};

  logic [0:0]          r_state;
  logic [AW-1:0]       r_idx;
  logic [NREGS-1:0]    r_busy;
  logic [XLEN-1:0]     r_regs [NREGS];

  logic                w_run;
  logic                w_wr_ok;
  logic                w_rsv_ok;
  logic [NRD*XLEN-1:0] w_rd_data;
  logic [NRD-1:0]      w_rd_busy;

  // A clear request drops any same-cycle write or reserve.
  assign w_run    = (r_state == ST_RUN);
  assign w_wr_ok  = w_run && !bus.clr_req && bus.wr_en  && (bus.wr_addr  != ADDR_ZERO);
  assign w_rsv_ok = w_run && !bus.clr_req && bus.rsv_en && (bus.rsv_addr != ADDR_ZERO);

  // Sweep FSM, sweep index and busy scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_idx   <= IDX_FIRST;
      r_busy  <= {NREGS{1'b0}};
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_busy <= {NREGS{1'b0}};
          if (r_idx == IDX_LAST) begin
            r_state <= ST_RUN;
          end else begin
            r_idx <= r_idx + IDX_FIRST;
          end
        end
        ST_RUN: begin
          if (bus.clr_req) begin
            r_state <= ST_CLEAR;
            r_idx   <= IDX_FIRST;
            r_busy  <= {NREGS{1'b0}};
          end else begin
            // Reserve is applied last so a new producer wins over a retire.
            if (w_wr_ok) begin
              r_busy[bus.wr_addr] <= 1'b0;
            end
            if (w_rsv_ok) begin
              r_busy[bus.rsv_addr] <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_idx   <= IDX_FIRST;
          r_busy  <= {NREGS{1'b0}};
        end
      endcase
    end
  end

  // Data array: no reset, zeroed by the sweep instead.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_regs[r_idx] <= {XLEN{1'b0}};
    end else if (w_wr_ok) begin
      r_regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Zero-latency read ports with write and retire bypass.
  always_comb begin
    w_rd_data = {(NRD*XLEN){1'b0}};
    w_rd_busy = {NRD{1'b0}};
    for (int i = 0; i < NRD; i++) begin
      if (!w_run || (bus.rd_addr[i*AW +: AW] == ADDR_ZERO)) begin
        w_rd_data[i*XLEN +: XLEN] = {XLEN{1'b0}};
        w_rd_busy[i]              = 1'b0;
      end else if (bus.wr_en && (bus.wr_addr == bus.rd_addr[i*AW +: AW])) begin
        w_rd_data[i*XLEN +: XLEN] = bus.wr_data;
        w_rd_busy[i]              = 1'b0;
      end else begin
        w_rd_data[i*XLEN +: XLEN] = r_regs[bus.rd_addr[i*AW +: AW]];
        w_rd_busy[i]              = r_busy[bus.rd_addr[i*AW +: AW]];
      end
    end
  end

  assign bus.rd_data = w_rd_data;
  assign bus.rd_busy = w_rd_busy;
  assign bus.ready   = w_run;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised multi-read-port register file for the pipelined core, generalising the 32x32 two-read/one-write file. It adds three things: a configurable number of read ports, a per-register pending (busy) scoreboard with reserve/retire semantics for hazard detection, and a sequential clear engine that zeroes the array after reset or on request. It sits between decode (reads, reserves) and writeback (retire writes).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >= 4); register 0 hardwired to zero
NRD, 2, number of read ports
AW, $clog2(NREGS), address width (derived; not to be overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rd_addr  input  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
rd_data  output  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]
rd_busy  output  NRD  1 = register on port i has an outstanding reservation
wr_en  input  1  writeback (retire) strobe
wr_addr  input  AW  writeback destination
wr_data  input  XLEN  writeback value
rsv_en  input  1  reserve strobe from decode
rsv_addr  input  AW  register to mark pending
clr_req  input  1  single-cycle request to re-run the clear sweep
ready  output  1  1 = file is usable; 0 while clear sweep is active

Behaviour:
- Reset (rst_n low, asynchronous): FSM -> CLEAR; sweep index -> 1; all busy bits -> 0; ready -> 0. The array itself is not asynchronously reset.
- CLEAR: each rising edge writes 0 to registers[index] and increments index. The sweep covers 1..NREGS-1, i.e. NREGS-1 edges. The edge that clears NREGS-1 moves the FSM to RUN, so ready = 1 from that edge onward. With defaults, ready rises on the 31st edge after rst_n deasserts.
- CLEAR: wr_en and rsv_en are ignored. rd_data = 0 and rd_busy = 0 on all ports.
- RUN: ready = 1. clr_req = 1 sampled on an edge -> next state CLEAR, index -> 1, all busy bits -> 0 on that same edge. Any wr_en/rsv_en in that cycle is dropped.
- clr_req while already in CLEAR: ignored; the sweep is not restarted.
- Write (RUN): when wr_en and wr_addr != 0, registers[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Reserve (RUN): when rsv_en and rsv_addr != 0, busy[rsv_addr] <= 1.
- Simultaneous reserve and write to the same nonzero address: the data is written and busy ends at 1, because the reserve is a new producer and wins.
- Reserve of an already-busy register: busy stays 1. There is no count and no error.
- Register 0: never written, never busy; rd_data = 0 and rd_busy = 0 for address 0 in every state.
- Read (RUN, combinational, zero latency), per port i with address a:
  - a == 0 -> data 0, busy 0
  - else wr_en && wr_addr == a -> data = wr_data (write bypass), busy = 0 (retire bypass)
  - else -> data = registers[a], busy = busy[a]
  - A same-cycle reserve is not bypassed; it is visible on rd_busy from the next cycle.
- Read ports are fully independent; any ports may address the same register.
- Reset mid-sweep or mid-operation: asynchronous return to the reset state. The sweep restarts from index 1 after rst_n rises.
- No X on any output after reset.

Test Plan:
1. Reset then idle -> ready = 0 for exactly 31 edges after rst_n rises, then 1. All ports read 0 for addresses 0..31. Pre-load the array with 0xDEADBEEF via backdoor before reset to prove the sweep clears it.
2. RUN: write x5 = 0x12345678 with rd_addr port0 = 5 in the same cycle -> port0 reads 0x12345678 combinationally. Next cycle, with wr_en = 0, it still reads 0x12345678.
3. Reserve x7 -> rd_busy[0] = 0 that cycle, 1 next cycle. Write x7 = 0xA5 -> rd_busy = 0 in the write cycle (bypass) and after, data = 0xA5.
4. Same-cycle rsv_en and wr_en on x9 with 0x55 -> x9 = 0x55 and rd_busy = 1 next cycle. Attempts to write or reserve x0 -> x0 reads 0, not busy.
5. In RUN, x3 = 0x77 with x3 reserved: pulse clr_req -> ready = 0 next cycle, busy cleared, wr_en during the sweep dropped. After 31 edges, ready = 1 and x3 = 0.
6. Assert rst_n low mid-sweep at index 12 -> ready = 0 immediately. After release the full 31-edge sweep repeats. Also run NRD = 4, NREGS = 16 to confirm a 15-edge sweep and four independent ports.
